mul_seq: RTL and testbench
==========================

MUL_SEQ -- requirements
Module: mul_seq

Interface
REQ-001 SHALL have parameter MAG_W, default 30: magnitude bits per operand; sign is bit MAG_W.
REQ-002 SHALL have parameter DIGIT_W, default 3: multiplier bits retired per cycle; MAG_W % DIGIT_W == 0; N = MAG_W/DIGIT_W (default 10).
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request; operands sampled in same cycle.
REQ-006 SHALL have port in1  input  MAG_W+1  multiplicand, signed-magnitude (bit MAG_W = sign).
REQ-007 SHALL have port in2  input  MAG_W+1  multiplier, signed-magnitude.
REQ-008 SHALL have port out  output  2*MAG_W  product magnitude.
REQ-009 SHALL have port sign  output  1  product sign.
REQ-010 SHALL have port busy  output  1  operation in progress; start ignored.
REQ-011 SHALL have port stop  output  1  one-cycle pulse: out/sign final.

Function
REQ-012 SHALL implement states IDLE, RUN, DONE; start accepted only in IDLE or DONE.
REQ-013 Accepted start (cycle 0) SHALL latch in1/in2 magnitudes, set sign = in1[MAG_W]^in2[MAG_W], clear out, load digit counter 0, enter RUN.
REQ-014 In RUN, each edge SHALL do out <= (out << DIGIT_W) + a * next multiplier digit, MSB digit first; full 2*MAG_W-bit arithmetic, no truncation.
REQ-015 After N RUN edges, state SHALL become DONE: busy high cycles 1..N, stop high in cycle N+1 only, busy low in cycle N+1.
REQ-016 DONE SHALL last one cycle, then IDLE unless a start is accepted in that cycle (back-to-back, new op busy from cycle N+2).
REQ-017 out and sign SHALL hold final values from stop until the next accepted start.
REQ-018 start while busy SHALL be ignored: no operand capture, no timing change.
REQ-019 Zero product SHALL keep sign = sa^sb (minus zero preserved).
REQ-020 Digit counter SHALL be ceil(log2(N+1)) bits; no wrap beyond N-1.

Reset
REQ-021 reset SHALL immediately force IDLE, out=0, sign=0, busy=0, stop=0, counter=0, operand registers 0.
REQ-022 Reset mid-operation SHALL abandon it; no stop pulse after release; first start after release behaves as REQ-013.

Configuration
REQ-023 Macro MUL_ZERO_BYPASS_EN defined: accepted start with either magnitude zero SHALL skip RUN, enter DONE directly (stop in cycle 1, busy never high), out=0, sign per REQ-019.
REQ-024 Macro MUL_ZERO_BYPASS_EN undefined: zero operands SHALL take full N-cycle path, identical result, stop in cycle N+1.

Verification (defaults MAG_W=30, DIGIT_W=3, start in cycle 0)
REQ-025 in1=+5, in2=-7 -> out=35, sign=1, busy cycles 1-10, stop in cycle 11 only.
REQ-026 in1=in2=+(2^30-1) -> out=0x0FFFFFFF80000001, sign=0, stop cycle 11.
REQ-027 op +3*+4, start with +9*+9 in cycle 5 -> ignored, out=12 at stop cycle 11; start in cycle 11 with +9*+9 -> out=81, stop cycle 22.
REQ-028 op running, reset pulsed cycle 4 -> out=0, busy=0 immediately, no stop; next start +2*+2 -> out=4 eleven cycles later.
REQ-029 in1=-0, in2=+3 -> out=0, sign=1; stop cycle 1 with MUL_ZERO_BYPASS_EN, cycle 11 without.

Source files
------------

// File: rtl/mul_seq_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mul_seq_if                                                         |
// | Request/response bundle for the digit-serial signed-magnitude      |
// | multiplier mul_seq. The master issues start with both operands;    |
// | the slave returns the product magnitude, sign, busy and stop.      |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
interface mul_seq_if #(
  parameter int MAG_W = 30
);
  logic               start;
  logic [MAG_W:0]     in1;
  logic [MAG_W:0]     in2;
  logic [2*MAG_W-1:0] out;
  logic               sign;
  logic               busy;
  logic               stop;

  modport master (
    output start, in1, in2,
    input  out, sign, busy, stop
  );

  modport slave (
    input  start, in1, in2,
    output out, sign, busy, stop
  );
endinterface
`default_nettype wire

// File: rtl/mul_seq.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mul_seq                                                            |
// | Sequential signed-magnitude multiplier. Retires DIGIT_W multiplier |
// | bits per clock, most significant digit first, accumulating into a  |
// | full-width 2*MAG_W product. Sign is the XOR of the operand signs,  |
// | so a zero product may carry a negative sign.                       |
// | Optional feature macro: MUL_ZERO_BYPASS_EN -- a zero operand skips |
// | the iterative phase and completes in one cycle.                    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module mul_seq #(
  parameter int MAG_W   = 30,
  parameter int DIGIT_W = 3
) (
  input  wire logic   clk,
  input  wire logic   reset,
  mul_seq_if.slave    bus
);

  localparam int N      = MAG_W / DIGIT_W;
  localparam int CNT_W  = $clog2(N + 1);
  localparam int PROD_W = 2 * MAG_W;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [MAG_W-1:0]  r_a;
  logic [MAG_W-1:0]  r_b;
  logic [PROD_W-1:0] r_out;
  logic              r_sign;

  logic              w_accept;
  logic              w_skip_run;
  logic [DIGIT_W-1:0] w_digit;
  logic [PROD_W-1:0] w_partial;
  logic [PROD_W-1:0] w_next_out;

  // A new request is only taken when no multiplication is iterating.
  assign w_accept = bus.start && (r_state != S_RUN);

`ifdef MUL_ZERO_BYPASS_EN
  // Either zero magnitude already fixes the product at zero.
  assign w_skip_run = (bus.in1[MAG_W-1:0] == '0) || (bus.in2[MAG_W-1:0] == '0);
`else
  assign w_skip_run = 1'b0;
`endif

  // The multiplier register is shifted left each step, so its top digit
  // is always the next one to retire (MSB digit first).
  assign w_digit    = r_b[MAG_W-1 -: DIGIT_W];
  assign w_partial  = PROD_W'(r_a) * PROD_W'(w_digit);
  assign w_next_out = (r_out << DIGIT_W) + w_partial;

  // Control, operand capture and Horner-style accumulation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_out   <= '0;
      r_sign  <= 1'b0;
    end else if (w_accept) begin
      r_a     <= bus.in1[MAG_W-1:0];
      r_b     <= bus.in2[MAG_W-1:0];
      r_sign  <= bus.in1[MAG_W] ^ bus.in2[MAG_W];
      r_out   <= '0;
      r_cnt   <= '0;
      r_state <= w_skip_run ? S_DONE : S_RUN;
    end else begin
      case (r_state)
        S_RUN: begin
          r_out <= w_next_out;
          r_b   <= r_b << DIGIT_W;
          if (r_cnt == CNT_W'(N - 1)) begin
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.out  = r_out;
  assign bus.sign = r_sign;
  assign bus.busy = (r_state == S_RUN);
  assign bus.stop = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_mul_seq.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_mul_seq                                                         |
// | Scoreboard bench for mul_seq: the driver predicts each accepted    |
// | request from plain arithmetic and queues it; a monitor compares    |
// | stop timing, busy, product and sign every cycle.                   |
// | Build with +define+MUL_ZERO_BYPASS_EN to match a bypass build.     |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_mul_seq;

  localparam int MAG_W   = 30;
  localparam int DIGIT_W = 3;
  localparam int N       = MAG_W / DIGIT_W;

  typedef struct {
    logic [2*MAG_W-1:0] out;
    logic               sgn;
    int                 start_cyc;
    int                 stop_cyc;
    bit                 bypass;
  } exp_t;

  logic clk;
  logic reset;
  int   cyc;
  int   n_checks;
  int   n_pass;
  int   busy_until;
  exp_t sb[$];
  logic [2*MAG_W-1:0] last_out;
  logic               last_sign;
  bit                 have_last;

  mul_seq_if #(.MAG_W(MAG_W)) bus ();

  mul_seq #(.MAG_W(MAG_W), .DIGIT_W(DIGIT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_checks++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp_v, cyc);
  endtask

  // Drive point: just after the rising edge that opens a cycle.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Present one request for one cycle and predict its outcome.
  task automatic issue(input logic [MAG_W:0] a, input logic [MAG_W:0] b);
    exp_t e;
    bus.start = 1'b1;
    bus.in1   = a;
    bus.in2   = b;
    if (cyc >= busy_until) begin
      e.out       = (2*MAG_W)'(a[MAG_W-1:0]) * (2*MAG_W)'(b[MAG_W-1:0]);
      e.sgn       = a[MAG_W] ^ b[MAG_W];
      e.start_cyc = cyc;
`ifdef MUL_ZERO_BYPASS_EN
      e.bypass    = (a[MAG_W-1:0] == 0) || (b[MAG_W-1:0] == 0);
`else
      e.bypass    = 1'b0;
`endif
      e.stop_cyc  = e.bypass ? cyc + 1 : cyc + N + 1;
      busy_until  = e.stop_cyc;
      sb.push_back(e);
    end
    step();
    bus.start = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (sb.size() != 0 && guard < 4 * N) begin
      step();
      guard++;
    end
    if (sb.size() != 0) begin
      chk("drain_timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
  endtask

  function automatic logic [MAG_W:0] rand_op();
    logic [MAG_W-1:0] m;
    int sel;
    sel = $urandom_range(0, 7);
    if (sel == 0)      m = '0;
    else if (sel == 1) m = '1;
    else               m = MAG_W'($urandom);
    return {1'($urandom_range(0, 1)), m};
  endfunction

  // Monitor: per-cycle comparison against the oldest pending prediction.
  always @(negedge clk) begin
    logic exp_busy;
    exp_busy = 1'b0;
    if (sb.size() != 0 && !sb[0].bypass &&
        cyc >= sb[0].start_cyc + 1 && cyc <= sb[0].start_cyc + N)
      exp_busy = 1'b1;
    chk("busy", 64'(bus.busy), 64'(exp_busy));
    if (sb.size() != 0 && cyc == sb[0].stop_cyc) begin
      chk("stop", 64'(bus.stop), 64'd1);
      chk("out", 64'(bus.out), 64'(sb[0].out));
      chk("sign", 64'(bus.sign), 64'(sb[0].sgn));
      last_out  = sb[0].out;
      last_sign = sb[0].sgn;
      have_last = 1'b1;
      void'(sb.pop_front());
    end else begin
      chk("stop", 64'(bus.stop), 64'd0);
      if (sb.size() == 0 && have_last) begin
        chk("hold_out", 64'(bus.out), 64'(last_out));
        chk("hold_sign", 64'(bus.sign), 64'(last_sign));
      end
    end
  end

  initial begin
    #300000;
    n_checks++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    int k;
    n_checks   = 0;
    n_pass     = 0;
    busy_until = 0;
    have_last  = 1'b0;
    reset      = 1'b1;
    bus.start  = 1'b0;
    bus.in1    = '0;
    bus.in2    = '0;
    repeat (3) step();
    chk("rst_out", 64'(bus.out), 64'd0);
    chk("rst_sign", 64'(bus.sign), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_stop", 64'(bus.stop), 64'd0);
    reset = 1'b0;
    step();

    // +5 * -7
    issue({1'b0, 30'd5}, {1'b1, 30'd7});
    drain();
    // largest magnitudes
    issue({1'b0, {MAG_W{1'b1}}}, {1'b0, {MAG_W{1'b1}}});
    drain();

    // start while busy is ignored, then back-to-back from DONE
    k = cyc;
    issue({1'b0, 30'd3}, {1'b0, 30'd4});
    repeat (4) step();
    issue({1'b0, 30'd9}, {1'b0, 30'd9});
    while (cyc < k + N + 1) step();
    issue({1'b0, 30'd9}, {1'b0, 30'd9});
    drain();

    // minus zero times +3
    issue({1'b1, 30'd0}, {1'b0, 30'd3});
    drain();

    // reset in the middle of an operation
    issue({1'b0, 30'd5}, {1'b0, 30'd6});
    repeat (3) step();
    reset = 1'b1;
    sb.delete();
    have_last  = 1'b0;
    busy_until = 0;
    #1;
    chk("midrst_out", 64'(bus.out), 64'd0);
    chk("midrst_busy", 64'(bus.busy), 64'd0);
    chk("midrst_stop", 64'(bus.stop), 64'd0);
    step();
    reset = 1'b0;
    repeat (2) step();
    issue({1'b0, 30'd2}, {1'b0, 30'd2});
    drain();

    // random traffic with random gaps (some land while busy)
    repeat (60) begin
      issue(rand_op(), rand_op());
      repeat ($urandom_range(0, 13)) step();
    end
    drain();
    repeat (3) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
